seq_shifter: RTL and testbench

//  Multi-cycle, parametrised shifter for the datapath shift stage. Generalises the fixed 1-bit shift
//  to WIDTH-bit operands, variable shift amount and STEP bits/cycle, with valid/ready handshakes
//  on both sides. Sits between register-file read and ALU B input; the FSM controller stalls on in_ready.

---
 rtl/seq_shifter_pkg.sv | 20 ++
 rtl/seq_shifter_shift_step.sv | 53 +++++
 rtl/seq_shifter.sv | 134 +++++++++++++
 tb/tb_seq_shifter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shifter_pkg.sv
// shifter_pkg: shared shift-stage types for the decoder, controller and the
// multi-cycle shifter.
//   shift_op_e : operation encoding carried on in_op
//   state_e    : shifter controller states
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// shift_step: combinational shift of a WIDTH-bit word by k bits (k < WIDTH)
// for one shift operation.
// Optional feature macro: SEQ_SHIFTER_CARRY_EN (adds the carry output).
// Ports:
//   data  : word to shift
//   op    : shift_op_e encoding (none / LSL / LSR / ASR)
//   k     : shift distance for this step
//   res   : shifted word
//   carry : last bit shifted out, 0 when k==0 or op none (carry builds only)
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] k,
  output logic [WIDTH-1:0] res
`ifdef SEQ_SHIFTER_CARRY_EN
  ,
  output logic             carry
`endif
);

  logic signed [WIDTH-1:0] data_s;
  assign data_s = data;

  always_comb begin
    res = data;
    case (shift_op_e'(op))
      SH_LSL:  res = data << k;
      SH_LSR:  res = data >> k;
      SH_ASR:  res = data_s >>> k;
      default: res = data;
    endcase
  end

`ifdef SEQ_SHIFTER_CARRY_EN
  always_comb begin
    carry = 1'b0;
    if (k != '0) begin
      case (shift_op_e'(op))
        SH_LSL:  carry = data[AMT_W'(WIDTH - int'(k))];
        SH_LSR,
        SH_ASR:  carry = data[k - AMT_W'(1)];
        default: carry = 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter for the datapath shift stage. Shifts a
// WIDTH-bit operand by 0..WIDTH-1 bits, STEP bits per cycle, with valid/ready
// handshakes on both sides.
// Optional feature macro: SEQ_SHIFTER_CARRY_EN (adds out_carry and its register).
// Ports:
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready only in IDLE)
//   in_data/in_op/in_amt: operand, shift_op_e encoding, shift amount
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   out_data            : shifted result
//   out_carry           : last bit shifted out (carry builds only)
module seq_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SEQ_SHIFTER_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  state_e           state;
  logic [AMT_W-1:0] rem;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       op_q;

  logic             accept;
  logic [WIDTH-1:0] step_in;
  logic [1:0]       op_src;
  logic [AMT_W-1:0] rem_src;
  logic [AMT_W-1:0] k;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] step_res;
`ifdef SEQ_SHIFTER_CARRY_EN
  logic             step_carry;
  logic             carry_q;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign out_data  = data_q;
`ifdef SEQ_SHIFTER_CARRY_EN
  assign out_carry = carry_q;
`endif

  // The first step is taken on the accepting edge straight from the request
  // inputs, so a shift finishes ceil(amt/STEP) cycles after acceptance; an
  // amount of at most STEP therefore goes directly from IDLE to DONE.
  always_comb begin
    step_in = data_q;
    op_src  = op_q;
    rem_src = rem;
    if (state == S_IDLE) begin
      step_in = in_data;
      op_src  = in_op;
      rem_src = in_amt;
    end
    if (32'(rem_src) >= STEP) k = AMT_W'(STEP);
    else                      k = rem_src;
    rem_next = rem_src - k;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_step (
    .data  (step_in),
    .op    (op_src),
    .k     (k),
    .res   (step_res)
`ifdef SEQ_SHIFTER_CARRY_EN
    ,
    .carry (step_carry)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      rem    <= '0;
      data_q <= '0;
      op_q   <= '0;
`ifdef SEQ_SHIFTER_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            data_q <= step_res;
`ifdef SEQ_SHIFTER_CARRY_EN
            carry_q <= step_carry;
`endif
            if (shift_op_e'(in_op) == SH_NONE || rem_next == '0) begin
              rem   <= '0;
              state <= S_DONE;
            end else begin
              rem   <= rem_next;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data_q <= step_res;
`ifdef SEQ_SHIFTER_CARRY_EN
          carry_q <= step_carry;
`endif
          rem <= rem_next;
          if (rem_next == '0) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Testbench for seq_shifter: one instance with STEP=1 and one with STEP=4,
// both WIDTH=16. Directed vector table, backpressure and mid-shift reset
// sequences, then a random sweep against a single-shot reference model.
module tb_seq_shifter;

  logic        clk;
  logic        reset_n;
  logic        iv   [2];
  logic        rdy  [2];
  logic [15:0] idat [2];
  logic [1:0]  iop  [2];
  logic [3:0]  iamt [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [15:0] od   [2];
`ifdef SEQ_SHIFTER_CARRY_EN
  logic        oc   [2];
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (iv[0]),
    .in_ready  (rdy[0]),
    .in_data   (idat[0]),
    .in_op     (iop[0]),
    .in_amt    (iamt[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .out_data  (od[0])
`ifdef SEQ_SHIFTER_CARRY_EN
    ,
    .out_carry (oc[0])
`endif
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (iv[1]),
    .in_ready  (rdy[1]),
    .in_data   (idat[1]),
    .in_op     (iop[1]),
    .in_amt    (iamt[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .out_data  (od[1])
`ifdef SEQ_SHIFTER_CARRY_EN
    ,
    .out_carry (oc[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single-shot reference: returns {carry, result}.
  function automatic logic [16:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                            input int amt);
    logic [15:0] r;
    logic [15:0] t;
    logic        c;
    r = d;
    c = 1'b0;
    case (op)
      2'b01: begin
        r = d << amt;
        t = d >> (16 - amt);
        if (amt > 0) c = t[0];
      end
      2'b10: begin
        r = d >> amt;
        t = d >> (amt - 1);
        if (amt > 0) c = t[0];
      end
      2'b11: begin
        r = $unsigned($signed(d) >>> amt);
        t = d >> (amt - 1);
        if (amt > 0) c = t[0];
      end
      default: ;
    endcase
    return {c, r};
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input int amt, input int step);
    if (op == 2'b00 || amt == 0) return 1;
    return (amt + step - 1) / step;
  endfunction

  // Issue one request on instance d, measure latency, hold bp cycles in DONE,
  // then complete the output handshake.
  task automatic do_op(input int d, input logic [15:0] data, input logic [1:0] op,
                       input logic [3:0] amt, input logic [15:0] exp_d, input logic exp_c,
                       input int exp_lat, input int bp, input string name);
    int lat;
    lat = 0;
    while (!rdy[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " in_ready"}, 32'(rdy[d]), 32'd1);
    iv[d] = 1'b1; idat[d] = data; iop[d] = op; iamt[d] = amt;
    @(posedge clk); #1;
    iv[d] = 1'b0; idat[d] = 16'($urandom); iop[d] = 2'($urandom); iamt[d] = 4'($urandom);
    lat = 1;
    while (!ov[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " data"}, 32'(od[d]), 32'(exp_d));
`ifdef SEQ_SHIFTER_CARRY_EN
    chk({name, " carry"}, 32'(oc[d]), 32'(exp_c));
`else
    if (exp_c === 1'bx) $display("note: unknown expected carry in %s", name);
`endif
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({name, " hold data"}, 32'(od[d]), 32'(exp_d));
      chk({name, " hold valid"}, 32'(ov[d]), 32'd1);
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk({name, " valid after take"}, 32'(ov[d]), 32'd0);
    chk({name, " ready after take"}, 32'(rdy[d]), 32'd1);
  endtask

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] exp_d;
    logic        exp_c;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [16:0] r;
    int          d;
    logic [15:0] data;
    logic [1:0]  op;
    logic [3:0]  amt;

    vecs[0]  = '{0, 16'h8001, 2'b01, 4'd3,  16'h0008, 1'b0, 3};
    vecs[1]  = '{0, 16'h0003, 2'b10, 4'd1,  16'h0001, 1'b1, 1};
    vecs[2]  = '{0, 16'h8010, 2'b11, 4'd4,  16'hF801, 1'b0, 4};
    vecs[3]  = '{0, 16'hBEEF, 2'b00, 4'd5,  16'hBEEF, 1'b0, 1};
    vecs[4]  = '{0, 16'hBEEF, 2'b01, 4'd0,  16'hBEEF, 1'b0, 1};
    vecs[5]  = '{0, 16'h8000, 2'b10, 4'd15, 16'h0001, 1'b0, 15};
    vecs[6]  = '{0, 16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 15};
    vecs[7]  = '{0, 16'h0003, 2'b01, 4'd15, 16'h8000, 1'b1, 15};
    vecs[8]  = '{1, 16'hC000, 2'b11, 4'd13, 16'hFFFE, 1'b0, 4};
    vecs[9]  = '{1, 16'hFFFF, 2'b01, 4'd4,  16'hFFF0, 1'b1, 1};
    vecs[10] = '{1, 16'h0005, 2'b10, 4'd3,  16'h0000, 1'b1, 1};
    vecs[11] = '{1, 16'h0003, 2'b01, 4'd15, 16'h8000, 1'b1, 4};

    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; idat[i] = '0; iop[i] = '0; iamt[i] = '0; ordy[i] = 1'b0;
    end
    reset_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset in_ready", 32'(rdy[i]), 32'd1);
      chk("reset out_valid", 32'(ov[i]), 32'd0);
      chk("reset out_data", 32'(od[i]), 32'd0);
`ifdef SEQ_SHIFTER_CARRY_EN
      chk("reset out_carry", 32'(oc[i]), 32'd0);
`endif
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].dut, vecs[i].data, vecs[i].op, vecs[i].amt, vecs[i].exp_d,
            vecs[i].exp_c, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));

    // Backpressure: result held, new request refused during and at the take.
    iv[0] = 1'b1; idat[0] = 16'h8001; iop[0] = 2'b01; iamt[0] = 4'd3;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp valid", 32'(ov[0]), 32'd1);
    iv[0] = 1'b1; idat[0] = 16'h1234; iop[0] = 2'b10; iamt[0] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp hold data", 32'(od[0]), 32'h0008);
      chk("bp in_ready", 32'(rdy[0]), 32'd0);
      chk("bp hold valid", 32'(ov[0]), 32'd1);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0; iv[0] = 1'b0;
    chk("bp after take valid", 32'(ov[0]), 32'd0);
    chk("bp after take ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    chk("bp no stray accept", 32'(rdy[0]), 32'd1);
    chk("bp no stray data", 32'(od[0]), 32'h0008);

    // Reset in the middle of a long shift.
    iv[0] = 1'b1; idat[0] = 16'h8000; iop[0] = 2'b10; iamt[0] = 4'd15;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midreset busy", 32'(rdy[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midreset in_ready", 32'(rdy[0]), 32'd1);
    chk("midreset out_valid", 32'(ov[0]), 32'd0);
    chk("midreset out_data", 32'(od[0]), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_op(0, 16'h00F0, 2'b10, 4'd4, 16'h000F, 1'b0, 4, 1, "after reset");

    // Random sweep against the reference model.
    for (int n = 0; n < 200; n++) begin
      d    = n % 2;
      data = 16'($urandom);
      op   = 2'($urandom);
      amt  = 4'($urandom);
      r    = ref_shift(data, op, int'(amt));
      do_op(d, data, op, amt, r[15:0], r[16], ref_lat(op, int'(amt), (d == 0) ? 1 : 4),
            int'($urandom_range(0, 2)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
